// File: rtl/i2s_transmitter_if.sv
// Sample stream handshake for the I2S transmitter: the producer drives a PCM sample
// with valid_in and the transmitter answers with ready_out.
`timescale 1ns/1ps

interface i2s_transmitter_if #(
   parameter int SAMPLE_WIDTH = 24
);
   logic signed [SAMPLE_WIDTH-1:0] sample_in;
   logic                           valid_in;
   logic                           ready_out;

   modport master (output sample_in, output valid_in, input ready_out);
   modport slave  (input sample_in, input valid_in, output ready_out);
endinterface

// File: rtl/i2s_transmitter.sv
// Master-mode I2S transmitter: FIFO-buffered mono PCM sent in both slots of a 64-bit frame.
// Define I2S_TX_HOLD_LAST_EN to repeat the previous sample on underrun instead of sending silence.
`timescale 1ns/1ps

module i2s_transmitter #(
   parameter int CLK_DIV      = 16,
   parameter int SAMPLE_WIDTH = 24,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   i2s_transmitter_if.slave stream,
   output logic             sclk_out,
   output logic             ws_out,
   output logic             sdata_out,
   output logic             underrun_out,
   output logic             frame_start_out
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int DIV_W = $clog2(CLK_DIV);

   logic [DIV_W-1:0]               div_cnt;
   logic [5:0]                     slot;
   logic [5:0]                     next_slot;
   logic signed [SAMPLE_WIDTH-1:0] frame_reg;
   logic signed [SAMPLE_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic signed [SAMPLE_WIDTH-1:0] fifo_head;
   logic [PTR_W:0]                 wr_ptr;
   logic [PTR_W:0]                 rd_ptr;
   logic                           div_tc;
   logic                           sclk_fall;
   logic                           load_edge;
   logic                           fifo_empty;
   logic                           fifo_full;
   logic                           push;

   // ws leads each word's MSB by one slot: high for slots 31..62.
   function automatic logic ws_for_slot(input logic [5:0] s);
      return (s >= 6'd31) && (s <= 6'd62);
   endfunction

   // Left-align the sample in 32 bits so slots past SAMPLE_WIDTH fall on zero padding.
   function automatic logic slot_bit(input logic [SAMPLE_WIDTH-1:0] frame, input logic [5:0] s);
      logic [31:0] aligned;
      aligned = 32'(frame) << (32 - SAMPLE_WIDTH);
      return aligned[5'd31 - s[4:0]];
   endfunction

   assign div_tc     = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign sclk_fall  = div_tc && sclk_out;
   assign next_slot  = slot + 6'd1;
   assign load_edge  = sclk_fall && (slot == 6'd62);
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign fifo_head  = fifo_mem[rd_ptr[PTR_W-1:0]];

   assign stream.ready_out = rst_in && !fifo_full;
   assign push             = stream.valid_in && stream.ready_out;

   always_ff @(posedge clk_in) begin
      if (push) begin
         fifo_mem[wr_ptr[PTR_W-1:0]] <= stream.sample_in;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         div_cnt         <= '0;
         sclk_out        <= 1'b0;
         slot            <= 6'd63;
         ws_out          <= 1'b0;
         sdata_out       <= 1'b0;
         underrun_out    <= 1'b0;
         frame_start_out <= 1'b0;
         frame_reg       <= '0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
      end else begin
         underrun_out    <= load_edge && fifo_empty;
         frame_start_out <= sclk_fall && (slot == 6'd63);

         if (div_tc) begin
            div_cnt  <= '0;
            sclk_out <= ~sclk_out;
         end else begin
            div_cnt  <= div_cnt + DIV_W'(1);
         end

         // Slot 63 still sends the old word's LSB, so sdata reads frame_reg before the reload lands.
         if (sclk_fall) begin
            slot      <= next_slot;
            ws_out    <= ws_for_slot(next_slot);
            sdata_out <= slot_bit($unsigned(frame_reg), next_slot);
         end

`ifdef I2S_TX_HOLD_LAST_EN
         if (load_edge && !fifo_empty) begin
            frame_reg <= fifo_head;
         end
`else
         if (load_edge) begin
            frame_reg <= fifo_empty ? '0 : fifo_head;
         end
`endif

         if (load_edge && !fifo_empty) begin
            rd_ptr <= rd_ptr + (PTR_W+1)'(1);
         end
         if (push) begin
            wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter (CLK_DIV=2, 24-bit samples, 4-deep FIFO);
// a negedge monitor decodes each frame from sclk rises and queues it for the scenario tasks.
`timescale 1ns/1ps

module tb_i2s_transmitter;

   localparam int CLK_DIV = 2;
   localparam int SW      = 24;
   localparam int DEPTH   = 4;
   localparam logic [63:0] WS_EXP = 64'h0000_0001_FFFF_FFFE;

   logic clk_in = 1'b0;
   logic rst_in = 1'b0;
   logic sclk_out, ws_out, sdata_out, underrun_out, frame_start_out;

   i2s_transmitter_if #(.SAMPLE_WIDTH(SW)) stream_if ();

   i2s_transmitter #(
      .CLK_DIV(CLK_DIV), .SAMPLE_WIDTH(SW), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .stream(stream_if),
      .sclk_out(sclk_out), .ws_out(ws_out), .sdata_out(sdata_out),
      .underrun_out(underrun_out), .frame_start_out(frame_start_out)
   );

   always #5 clk_in = ~clk_in;

   int tests_run    = 0;
   int tests_failed = 0;

   // Frame decoder state
   logic [63:0] cap_d, cap_w;
   logic [63:0] q_d[$];
   logic [63:0] q_w[$];
   bit          q_u[$];
   int          cap_idx = 0;
   int          last_idx = -1;
   int          und_total = 0;
   bit          active = 0, frame_und = 0, prev_sclk = 0, prev_und = 0;
   bit          und_long = 0, rise_flag = 0;

   initial begin
      forever begin
         @(negedge clk_in);
         rise_flag = 0;
         if (!rst_in) begin
            active = 0; cap_idx = 0; und_total = 0; frame_und = 0;
            prev_sclk = 0; prev_und = 0;
            q_d.delete(); q_w.delete(); q_u.delete();
         end else begin
            if (underrun_out) begin
               und_total++;
               frame_und = 1;
               if (prev_und) und_long = 1;
            end
            prev_und = underrun_out;
            if (frame_start_out) begin
               active = 1; cap_idx = 0; frame_und = 0;
            end
            if (sclk_out && !prev_sclk && active) begin
               cap_d[63-cap_idx] = sdata_out;
               cap_w[63-cap_idx] = ws_out;
               last_idx  = cap_idx;
               rise_flag = 1;
               cap_idx++;
               if (cap_idx == 64) begin
                  q_d.push_back(cap_d); q_w.push_back(cap_w); q_u.push_back(frame_und);
                  active = 0; cap_idx = 0;
               end
            end
            prev_sclk = sclk_out;
         end
      end
   end

   function automatic logic [63:0] exp_frame(input logic [23:0] s);
      return {s, 8'h00, s, 8'h00};
   endfunction

   function automatic logic [23:0] after_underrun(input logic [23:0] last);
`ifdef I2S_TX_HOLD_LAST_EN
      return last;
`else
      return 24'h0 & last;
`endif
   endfunction

   task automatic get_frame(output logic [63:0] d, output logic [63:0] w, output bit u);
      int n;
      n = 0;
      while (q_d.size() == 0 && n < 600) begin
         @(negedge clk_in); #1; n++;
      end
      if (q_d.size() == 0) begin
         tests_run++; tests_failed++;
         $display("FAIL frame_timeout: no frame after %0d cycles, required one", n);
         d = 'x; w = 'x; u = 1'bx;
      end else begin
         d = q_d.pop_front(); w = q_w.pop_front(); u = q_u.pop_front();
      end
   endtask

   task automatic push_sample(input logic [23:0] s, output int waited);
      int n;
      n = 0;
      stream_if.sample_in = s;
      stream_if.valid_in  = 1'b1;
      while (stream_if.ready_out !== 1'b1 && n < 600) begin
         @(negedge clk_in); #1; n++;
      end
      waited = n;
      if (stream_if.ready_out !== 1'b1) begin
         tests_run++; tests_failed++;
         $display("FAIL push_timeout: sample %h not accepted in %0d cycles", s, n);
      end else begin
         @(posedge clk_in);
         @(negedge clk_in); #1;
      end
   endtask

   task automatic wait_slot(input int idx);
      int n;
      n = 0;
      do begin
         @(negedge clk_in); #1; n++;
      end while (!(rise_flag && last_idx == idx) && n < 600);
      if (!(rise_flag && last_idx == idx)) begin
         tests_run++; tests_failed++;
         $display("FAIL slot_timeout: slot %0d not reached, last %0d", idx, last_idx);
      end
   endtask

   task automatic check_frame(input string name, input logic [63:0] d, input logic [63:0] w,
                              input bit u, input logic [23:0] s, input bit u_exp);
      tests_run++;
      if (d !== exp_frame(s)) begin
         tests_failed++;
         $display("FAIL %s_data: got %h required %h", name, d, exp_frame(s));
      end
      tests_run++;
      if (w !== WS_EXP) begin
         tests_failed++;
         $display("FAIL %s_ws: got %h required %h", name, w, WS_EXP);
      end
      tests_run++;
      if (u !== u_exp) begin
         tests_failed++;
         $display("FAIL %s_underrun: got %0b required %0b", name, u, u_exp);
      end
   endtask

   // Entered at a negedge with rst_in held low for at least 10 cycles.
   task automatic check_release_timing(input string tag);
      logic [4:0] sv, fv;
      #1;
      tests_run++;
      if ({sclk_out, ws_out, sdata_out, underrun_out, frame_start_out, stream_if.ready_out} !== 6'b0) begin
         tests_failed++;
         $display("FAIL %s_reset_outputs: got %b required 000000", tag,
                  {sclk_out, ws_out, sdata_out, underrun_out, frame_start_out, stream_if.ready_out});
      end
      rst_in = 1'b1;
      #1;
      tests_run++;
      if (stream_if.ready_out !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s_ready_release: got %b required 1", tag, stream_if.ready_out);
      end
      for (int e = 0; e < 5; e++) begin
         @(negedge clk_in); #1;
         sv[4-e] = sclk_out;
         fv[4-e] = frame_start_out;
      end
      tests_run++;
      if (sv !== 5'b01100) begin
         tests_failed++;
         $display("FAIL %s_sclk_edges: got %b required 01100", tag, sv);
      end
      tests_run++;
      if (fv !== 5'b00010) begin
         tests_failed++;
         $display("FAIL %s_frame_start_edges: got %b required 00010", tag, fv);
      end
      tests_run++;
      if (und_total !== 0) begin
         tests_failed++;
         $display("FAIL %s_early_underrun: got %0d pulses required 0", tag, und_total);
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b0;
      stream_if.valid_in  = 1'b0;
      stream_if.sample_in = '0;
      repeat (10) @(negedge clk_in);
      check_release_timing("por");
   endtask

   task automatic test_serialization();
      logic [63:0] d, w; bit u; int wt;
      push_sample(24'hA5F00F, wt);
      stream_if.valid_in = 1'b0;
      get_frame(d, w, u);
      check_frame("first_frame", d, w, u, 24'h000000, 1'b0);
      get_frame(d, w, u);
      check_frame("serial", d, w, u, 24'hA5F00F, 1'b1);
   endtask

   task automatic test_underrun();
      logic [63:0] d, w; bit u; int wt;
      push_sample(24'h123456, wt);
      stream_if.valid_in = 1'b0;
      get_frame(d, w, u);
      check_frame("underrun_fill", d, w, u, after_underrun(24'hA5F00F), 1'b0);
      get_frame(d, w, u);
      check_frame("single_sample", d, w, u, 24'h123456, 1'b1);
      tests_run++;
      if (und_long !== 1'b0) begin
         tests_failed++;
         $display("FAIL underrun_width: multi-cycle pulse seen, required single cycle");
      end
   endtask

   task automatic test_backpressure();
      logic [23:0] s [6];
      logic [63:0] d, w; bit u; int wt;
      logic [5:0] uv;
      s = '{24'h800001, 24'h7FFFFE, 24'h000001, 24'hFFFFFF, 24'h3C3C3C, 24'hC3C3C3};
      for (int i = 0; i < 6; i++) begin
         push_sample(s[i], wt);
         if (i == 3) begin
            tests_run++;
            if (stream_if.ready_out !== 1'b0) begin
               tests_failed++;
               $display("FAIL ready_full: got %b required 0", stream_if.ready_out);
            end
         end
         if (i == 4) begin
            tests_run++;
            if (wt <= 200) begin
               tests_failed++;
               $display("FAIL fifth_wait: got %0d cycles required >200", wt);
            end
         end
      end
      stream_if.valid_in = 1'b0;
      get_frame(d, w, u);
      check_frame("hold_frame", d, w, u, after_underrun(24'h123456), 1'b0);
      for (int i = 0; i < 6; i++) begin
         get_frame(d, w, u);
         uv[5-i] = u;
         tests_run++;
         if (d !== exp_frame(s[i])) begin
            tests_failed++;
            $display("FAIL bp_frame%0d: got %h required %h", i, d, exp_frame(s[i]));
         end
      end
      tests_run++;
      if (uv !== 6'b000001) begin
         tests_failed++;
         $display("FAIL bp_underrun_flags: got %b required 000001", uv);
      end
      get_frame(d, w, u);
      check_frame("bp_tail", d, w, u, after_underrun(24'hC3C3C3), 1'b1);
   endtask

   task automatic test_simultaneous();
      logic [63:0] d, w; bit u;
      wait_slot(62);
      @(negedge clk_in); #1;
      stream_if.sample_in = 24'h5A5A5A;
      stream_if.valid_in  = 1'b1;
      @(negedge clk_in); #1;
      tests_run++;
      if (underrun_out !== 1'b1) begin
         tests_failed++;
         $display("FAIL simul_underrun_pulse: got %b required 1", underrun_out);
      end
      stream_if.valid_in = 1'b0;
      get_frame(d, w, u);
      tests_run++;
      if (u !== 1'b1) begin
         tests_failed++;
         $display("FAIL simul_frame_underrun: got %b required 1", u);
      end
      get_frame(d, w, u);
      check_frame("simul_gap", d, w, u, after_underrun(24'hC3C3C3), 1'b0);
      get_frame(d, w, u);
      check_frame("simul_sample", d, w, u, 24'h5A5A5A, 1'b1);
   endtask

   task automatic test_mid_frame_reset();
      logic [63:0] d, w; bit u; int wt;
      push_sample(24'h777777, wt);
      stream_if.valid_in = 1'b0;
      wait_slot(40);
      #2;
      rst_in = 1'b0;
      #1;
      tests_run++;
      if ({sclk_out, ws_out, sdata_out, underrun_out, frame_start_out, stream_if.ready_out} !== 6'b0) begin
         tests_failed++;
         $display("FAIL async_reset_outputs: got %b required 000000",
                  {sclk_out, ws_out, sdata_out, underrun_out, frame_start_out, stream_if.ready_out});
      end
      repeat (10) @(negedge clk_in);
      check_release_timing("mid");
      get_frame(d, w, u);
      check_frame("post_reset", d, w, u, 24'h000000, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_serialization();
      test_underrun();
      test_backpressure();
      test_simultaneous();
      test_mid_frame_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
